// File: rtl/axi_pmu_pkg.sv
// axi_pmu shared types: counter index map and event vector.
// Imported by the PMU top and its counter slice.
package axi_pmu_pkg;

  localparam int NUM_CNT = 16;

  typedef enum logic [3:0] {
    CNT_AW_HS    = 4'd0,
    CNT_W_BEAT   = 4'd1,
    CNT_W_LAST   = 4'd2,
    CNT_B_HS     = 4'd3,
    CNT_AR_HS    = 4'd4,
    CNT_R_BEAT   = 4'd5,
    CNT_R_LAST   = 4'd6,
    CNT_AW_STALL = 4'd7,
    CNT_W_STALL  = 4'd8,
    CNT_AR_STALL = 4'd9,
    CNT_R_STALL  = 4'd10,
    CNT_WR_LAT   = 4'd11,
    CNT_RD_LAT   = 4'd12,
    CNT_WR_MAX   = 4'd13,
    CNT_RD_MAX   = 4'd14,
    CNT_CYCLES   = 4'd15
  } cnt_idx_e;

  typedef logic [NUM_CNT-1:0] evt_t;

endpackage

// File: rtl/axi_if.sv
// AXI link bundle; the mon modport is a pure observer.
// Only the fields the PMU needs plus ID/addr/data.
interface axi_if #(
  parameter int ID_W_WIDTH     = 4,
  parameter int ID_R_WIDTH     = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int AXI_DATA_WIDTH = 32
) ();

  logic [ID_W_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;
  logic [ID_W_WIDTH-1:0]     bid;
  logic                      bvalid;
  logic                      bready;
  logic [ID_R_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic                      arvalid;
  logic                      arready;
  logic [ID_R_WIDTH-1:0]     rid;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;

  modport mon (
    input awid, awaddr, awvalid, awready,
    input wdata, wlast, wvalid, wready,
    input bid, bvalid, bready,
    input arid, araddr, arvalid, arready,
    input rid, rdata, rlast, rvalid, rready
  );

endinterface

// File: rtl/axi_pmu_cnt.sv
// One saturating statistic counter with clear and a
// snapshot register; the sum is one bit wider and clamped.
module axi_pmu_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         snap,
  input  logic [W-1:0] add,
  output logic [W-1:0] shadow
);

  logic [W-1:0] live;
  logic [W:0]   sum;
  logic [W-1:0] nxt;

  always_comb begin
    sum = {1'b0, live} + {1'b0, add};
    nxt = sum[W] ? '1 : sum[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live   <= '0;
      shadow <= '0;
    end else begin
      if (clr)
        live <= '0;
      else if (en)
        live <= nxt;
      // shadow sees the pre-clear value for gap-free sampling
      if (snap)
        shadow <= live;
    end
  end

endmodule

// File: rtl/axi_pmu.sv
// Passive AXI performance monitor: event counters, outstanding
// trackers, latency integrals and a snapshot read port.
module axi_pmu
  import axi_pmu_pkg::*;
#(
  parameter int ID_W_WIDTH     = 4,
  parameter int ID_R_WIDTH     = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int OUTST_WIDTH    = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  axi_if.mon                   mon,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 snap,
  input  logic [3:0]           rd_sel,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 err
);

  localparam int MW =
    (CNT_WIDTH > OUTST_WIDTH) ? CNT_WIDTH : OUTST_WIDTH;
  localparam logic [MW-1:0] CAP = MW'({CNT_WIDTH{1'b1}});

  typedef logic [OUTST_WIDTH-1:0] os_t;
  typedef logic [CNT_WIDTH-1:0]   cnt_t;

  // tracker values wider than a counter are clamped, not wrapped
  function automatic cnt_t clip(input os_t v);
    logic [MW-1:0] e;
    e = MW'(v);
    if (e > CAP)
      e = CAP;
    return e[CNT_WIDTH-1:0];
  endfunction

  localparam int AW_T = ID_W_WIDTH + ID_R_WIDTH
                      + ADDR_WIDTH + AXI_DATA_WIDTH;

  logic [AW_T-1:0] unused_a;
  logic [AW_T-1:0] unused_b;

  assign unused_a = {mon.awid, mon.rid,
                     mon.awaddr, mon.wdata};
  assign unused_b = {mon.bid, mon.arid,
                     mon.araddr, mon.rdata};

  evt_t ev;

  always_comb begin
    ev = '0;
    ev[CNT_AW_HS]    = mon.awvalid & mon.awready;
    ev[CNT_W_BEAT]   = mon.wvalid & mon.wready;
    ev[CNT_W_LAST]   = mon.wvalid & mon.wready & mon.wlast;
    ev[CNT_B_HS]     = mon.bvalid & mon.bready;
    ev[CNT_AR_HS]    = mon.arvalid & mon.arready;
    ev[CNT_R_BEAT]   = mon.rvalid & mon.rready;
    ev[CNT_R_LAST]   = mon.rvalid & mon.rready & mon.rlast;
    ev[CNT_AW_STALL] = mon.awvalid & ~mon.awready;
    ev[CNT_W_STALL]  = mon.wvalid & ~mon.wready;
    ev[CNT_AR_STALL] = mon.arvalid & ~mon.arready;
    ev[CNT_R_STALL]  = mon.rvalid & ~mon.rready;
    ev[CNT_CYCLES]   = 1'b1;
  end

  os_t  wr_os;
  os_t  rd_os;
  os_t  wr_nxt;
  os_t  rd_nxt;
  logic wr_bad;
  logic rd_bad;
  logic aw_hs;
  logic b_hs;
  logic ar_hs;
  logic r_end;

  assign aw_hs = ev[CNT_AW_HS];
  assign b_hs  = ev[CNT_B_HS];
  assign ar_hs = ev[CNT_AR_HS];
  assign r_end = ev[CNT_R_LAST];

  always_comb begin
    wr_nxt = wr_os;
    wr_bad = 1'b0;
    if (aw_hs && !b_hs) begin
      if (&wr_os) wr_bad = 1'b1;
      else        wr_nxt = wr_os + os_t'(1);
    end else if (b_hs && !aw_hs) begin
      if (wr_os == '0) wr_bad = 1'b1;
      else             wr_nxt = wr_os - os_t'(1);
    end
  end

  always_comb begin
    rd_nxt = rd_os;
    rd_bad = 1'b0;
    if (ar_hs && !r_end) begin
      if (&rd_os) rd_bad = 1'b1;
      else        rd_nxt = rd_os + os_t'(1);
    end else if (r_end && !ar_hs) begin
      if (rd_os == '0) rd_bad = 1'b1;
      else             rd_nxt = rd_os - os_t'(1);
    end
  end

  cnt_t add [NUM_CNT];
  cnt_t shadow [NUM_CNT];

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++)
      add[i] = cnt_t'(ev[i]);
    add[int'(CNT_WR_LAT)] = clip(wr_os);
    add[int'(CNT_RD_LAT)] = clip(rd_os);
  end

  cnt_t wr_max;
  cnt_t rd_max;
  cnt_t wr_max_sh;
  cnt_t rd_max_sh;
  cnt_t wr_cand;
  cnt_t rd_cand;

  assign wr_cand = clip(wr_nxt);
  assign rd_cand = clip(rd_nxt);

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    if (i == int'(CNT_WR_MAX)) begin : g_wmax
      assign shadow[i] = wr_max_sh;
    end else if (i == int'(CNT_RD_MAX)) begin : g_rmax
      assign shadow[i] = rd_max_sh;
    end else begin : g_sat
      axi_pmu_cnt #(
        .W (CNT_WIDTH)
      ) u_cnt (
        .clk    (ACLK),
        .rst_n  (ARESETn),
        .en     (en),
        .clr    (clr),
        .snap   (snap),
        .add    (add[i]),
        .shadow (shadow[i])
      );
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_os     <= '0;
      rd_os     <= '0;
      err       <= 1'b0;
      wr_max    <= '0;
      rd_max    <= '0;
      wr_max_sh <= '0;
      rd_max_sh <= '0;
      rd_data   <= '0;
    end else begin
      wr_os <= wr_nxt;
      rd_os <= rd_nxt;
      if (wr_bad || rd_bad)
        err <= 1'b1;
      if (clr) begin
        wr_max <= '0;
        rd_max <= '0;
      end else if (en) begin
        if (wr_cand > wr_max) wr_max <= wr_cand;
        if (rd_cand > rd_max) rd_max <= rd_cand;
      end
      if (snap) begin
        wr_max_sh <= wr_max;
        rd_max_sh <= rd_max;
      end
      rd_data <= shadow[rd_sel];
    end
  end

endmodule
